inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write-side counterpart of the byte-addressed instruction memory. Accepts 32-bit instruction
//  words over a valid/ready stream and writes them into the 8-bit-wide memory array as four
//  little-endian byte writes: byte 0 = word[7:0] at the lowest address.
//  Sits between the boot/test program source and the memory write port.
//  Runs before the pipeline fetches; the fetch side then reads back {b3,b2,b1,b0}.
// PARAMETERS
//  MEM_BYTES  16  memory size in bytes; must be a multiple of 4
//  ADDR_W     64  width of the byte address, matching the fetch address
//  CNT_W      16  width of the word-count input
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       one-cycle pulse; begins a load session. Honoured only in IDLE.
//  base_addr   in   ADDR_W  first byte address of the session; sampled on start
//  word_count  in   CNT_W   number of words in the session; sampled on start
//  in_valid    in   1       in_word is valid
//  in_ready    out  1       loader accepts in_word this cycle
//  in_word     in   32      instruction word to store
//  mem_we      out  1       byte write strobe to the memory
//  mem_addr    out  ADDR_W  byte address being written
//  mem_wdata   out  8       byte being written
//  busy        out  1       a session is in progress (state != IDLE)
//  done        out  1       one-cycle pulse at the end of a session
//  err         out  1       sticky; cleared by the next honoured start
// BEHAVIOUR
//  - Reset: state=IDLE. in_ready, mem_we, busy, done and err are 0. mem_addr=0, mem_wdata=0.
//    Reset is asynchronous: any mid-session write is aborted immediately and no further strobes issue.
//  - States: IDLE -> WAIT -> WR0 -> WR1 -> WR2 -> WR3 -> (WAIT | FIN) -> IDLE.
//  - IDLE: on start, latch addr=base_addr, remaining=word_count and clear err. Then:
//    - base_addr[1:0]!=0: set err, go to FIN.
//    - word_count==0: go to FIN.
//    - otherwise: go to WAIT.
//  - Accept: a word is taken when in_valid && in_ready.
//    - in_ready = (state==WAIT) || (state==WR3 && remaining>1).
//    - in_ready must not depend combinationally on in_valid.
//  - On accept, register the word. WRk then drives:
//    - mem_we=1, mem_addr=addr+k, mem_wdata=word[8k+7:8k].
//    - Byte writes begin the cycle after acceptance; 4 cycles per word.
//  - WR3 exit: addr+=4, remaining-=1.
//    - remaining reaches 0: go to FIN.
//    - a word was accepted in WR3: go to WR0 (back-to-back, 1 word per 4 cycles).
//    - else: go to WAIT.
//  - Bounds: if a word is accepted with addr+3 >= MEM_BYTES, issue no writes, set err, go to FIN.
//    Address arithmetic is ADDR_W wide; wrap-around is caught by the same bound check.
//  - FIN: done=1 for exactly one cycle, then IDLE. busy is 1 in WAIT, WRk and FIN.
//  - start outside IDLE is ignored. in_valid outside an accept window is ignored.
//  - mem_we=0 in every state other than WRk. mem_addr and mem_wdata hold their last value when mem_we=0.
// STRUCTURE
//  - Shared package inst_mem_pkg holds:
//    - state encoding (IDLE, WAIT, WR0..WR3, FIN);
//    - BYTES_PER_WORD=4;
//    - the byte-lane select function used by both this block and the fetch-side memory read.
//  - Single module, no sub-modules. The FSM, address and remaining-count registers and the
//    word holding register live in one always block with async reset; outputs are decoded from state.
// TESTING
//  1. base=0, count=4; words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423, valid held high.
//     -> 16 strobes at addr 0..15: 83 34 85 02 B3 84 9A 00 93 84 14 00 23 34 95 02.
//     -> done pulses 1 cycle after the last strobe; err=0; total 17 cycles from first accept.
//  2. Same session with in_valid low for 3 cycles between words.
//     -> loader stalls in WAIT with mem_we=0; byte order and addresses unchanged.
//  3. base=12, count=2.
//     -> first word written to 12..15; second word accepted but not written; err=1; done pulses.
//  4. base=2, count=1.
//     -> no accept, no strobes; err=1 and done on the cycle after start.
//  5. count=0 -> done one cycle after start, no strobes, err=0.
//     start pulsed again while busy -> ignored; session completes with original parameters.
//  6. Assert reset low during WR1 of word 2.
//     -> mem_we=0 immediately; busy=0, err=0.
//     -> new session after release re-writes from base with correct bytes.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the byte-wide instruction memory: loader FSM states,
// word geometry and the little-endian byte-lane select used by loader and fetch.
package inst_mem_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_WR3,
        ST_FIN
    } state_e;

    // Lane 0 is word[7:0], stored at the lowest byte address.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        byte_lane = word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory as four
// little-endian byte writes per word, with alignment and bounds checking.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int MEM_BYTES = 16,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_word_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] LAST_OFS  = ADDR_W'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              in_ready;
    logic              accept;
    logic              writing;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] next_word_addr;
    logic              out_of_bounds;

    // Ready is a function of state only, so it never loops back through in_valid.
    always_comb begin
        in_ready       = (state_q == ST_WAIT) ||
                         ((state_q == ST_WR3) && (remaining_q > CNT_W'(1)));
        accept         = in_ready && in_valid_i;
        next_word_addr = (state_q == ST_WR3) ? (addr_q + WORD_STEP) : addr_q;
        out_of_bounds  = (next_word_addr + LAST_OFS) >= MEM_LIMIT;
    end

    always_comb begin
        writing = 1'b1;
        lane    = 2'd0;
        case (state_q)
            ST_WR0:  lane = 2'd0;
            ST_WR1:  lane = 2'd1;
            ST_WR2:  lane = 2'd2;
            ST_WR3:  lane = 2'd3;
            default: writing = 1'b0;
        endcase
    end

    // Address and data hold their last driven value between strobes.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (writing) begin
            mem_addr_d  = addr_q + ADDR_W'(lane);
            mem_wdata_d = byte_lane(word_q, lane);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = word_count_i;
                    err_d       = 1'b0;
                    if (base_addr_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (word_count_i == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    if (out_of_bounds) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        word_d  = in_word_i;
                        state_d = ST_WR0;
                    end
                end
            end
            ST_WR0: state_d = ST_WR1;
            ST_WR1: state_d = ST_WR2;
            ST_WR2: state_d = ST_WR3;
            ST_WR3: begin
                addr_d      = addr_q + WORD_STEP;
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end else if (accept) begin
                    if (out_of_bounds) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        word_d  = in_word_i;
                        state_d = ST_WR0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign mem_we_o    = writing;
    assign mem_addr_o  = mem_addr_d;
    assign mem_wdata_o = mem_wdata_d;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN);
    assign err_o       = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: a session-level model predicts byte writes
// and the done/err outcome; a negedge monitor checks every strobe and done pulse.
module tb_inst_mem_loader;

    localparam int MEM_BYTES = 16;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b1;
    logic        start_i      = 1'b0;
    logic [63:0] base_addr_i  = '0;
    logic [15:0] word_count_i = '0;
    logic        in_valid_i   = 1'b0;
    logic [31:0] in_word_i    = '0;
    logic        in_ready_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .word_count_i(word_count_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_word_i(in_word_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [71:0] wr_q[$];    // {addr, data} per expected strobe
    logic        done_q[$];  // expected err at each done pulse
    logic [31:0] words[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe and every done pulse must match the head of its queue.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_we_o) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h, none expected",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    logic [71:0] e;
                    e = wr_q.pop_front();
                    $display("strobe addr=0x%0h data=0x%02h (exp addr=0x%0h data=0x%02h)",
                             mem_addr_o, mem_wdata_o, e[71:8], e[7:0]);
                    chk("strobe_addr", mem_addr_o, e[71:8]);
                    chk("strobe_data", 64'(mem_wdata_o), 64'(e[7:0]));
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: err %0b, no session pending", err_o);
                end else begin
                    logic e_err;
                    e_err = done_q.pop_front();
                    $display("done err=%0b (exp %0b)", err_o, e_err);
                    chk("done_err", 64'(err_o), 64'(e_err));
                end
            end
        end
    end

    task automatic run_session(input logic [63:0] base, input int count,
                               input int gmin, input int gmax, input bit poke);
        bit          early;
        bit          exp_err;
        bit          seen;
        int          n_acc;
        int          n_wr;
        int          idx;
        int          gap;
        int          t;
        logic [63:0] a;
        n_acc = 0; n_wr = 0; idx = 0; gap = 0; t = 0; seen = 0;

        // Reference: words go to consecutive aligned slots; a word whose last byte
        // would fall outside memory is taken but ends the session with an error.
        exp_err = (base % 4) != 0;
        early   = exp_err || (count == 0);
        if (!early) begin
            for (int i = 0; i < count; i++) begin
                a = base + 64'(4 * i);
                n_acc++;
                if (a + 64'd3 >= 64'(MEM_BYTES)) begin
                    exp_err = 1'b1;
                    break;
                end
                for (int b = 0; b < 4; b++)
                    wr_q.push_back({a + 64'(b), 8'((words[i] >> (8 * b)) & 32'hFF)});
                n_wr++;
            end
        end
        done_q.push_back(exp_err);

        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = base; word_count_i = 16'(count); in_valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0; t = 1;
        while (!seen && t < 300) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                start_i = 1'b0;
                if (poke && t == 3 && busy_o) begin
                    start_i = 1'b1; base_addr_i = 64'd4; word_count_i = 16'd1;
                end
                if (gap > 0) begin
                    in_valid_i = 1'b0;
                    gap--;
                end else if (idx < n_acc) begin
                    in_valid_i = 1'b1;
                    in_word_i  = words[idx];
                    if (in_ready_o) begin
                        idx++;
                        gap = int'($urandom_range(gmax, gmin));
                    end
                end else begin
                    in_valid_i = 1'b1;          // no accept window should open now
                    in_word_i  = $urandom;
                end
                @(negedge clk_i);
                t++;
            end
        end
        start_i = 1'b0; in_valid_i = 1'b0;
        $display("session base=0x%0h count=%0d gap=%0d..%0d poke=%0b: accepted %0d, done at +%0d",
                 base, count, gmin, gmax, poke, idx, t);
        chk("done_seen", 64'(seen), 64'd1);
        if (gmax == 0) chk("done_latency", 64'(t), early ? 64'd1 : 64'(2 + 4 * n_wr));
        chk("words_accepted", 64'(idx), 64'(n_acc));
        @(negedge clk_i);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("err_sticky", 64'(err_o), 64'(exp_err));
    endtask

    // Abort a base-0 session with reset while the second word is in its lane-1 write.
    task automatic reset_mid();
        int idx;
        int nstb;
        idx = 0; nstb = 0;
        for (int b = 0; b < 6; b++)
            wr_q.push_back({64'(b), 8'((words[b / 4] >> (8 * (b % 4))) & 32'hFF)});
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = 64'd0; word_count_i = 16'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (mem_we_o) nstb++;
            if (nstb == 6) break;
            in_valid_i = 1'b1;
            in_word_i  = words[idx];
            if (in_ready_o && idx < 3) idx++;
            @(negedge clk_i);
        end
        chk("abort_point_reached", 64'(nstb), 64'd6);
        #2 rst_ni = 1'b0;
        #1;
        $display("reset mid-session: we=%0b busy=%0b err=%0b", mem_we_o, busy_o, err_o);
        chk("abort_we", 64'(mem_we_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_err", 64'(err_o), 64'd0);
        chk("abort_ready", 64'(in_ready_o), 64'd0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        $display("reset: ready=%0b we=%0b busy=%0b done=%0b err=%0b addr=0x%0h data=0x%0h",
                 in_ready_o, mem_we_o, busy_o, done_o, err_o, mem_addr_o, mem_wdata_o);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_we", 64'(mem_we_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_addr", mem_addr_o, 64'd0);
        chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
        rst_ni = 1'b1;

        words[0] = 32'h02853483; words[1] = 32'h009A84B3;
        words[2] = 32'h00148493; words[3] = 32'h02953423;
        for (int i = 4; i < 8; i++) words[i] = $urandom;

        run_session(64'd0, 4, 0, 0, 1'b0);     // back-to-back stream
        run_session(64'd0, 4, 3, 3, 1'b0);     // 3-cycle gaps between words
        run_session(64'd12, 2, 0, 0, 1'b0);    // second word out of bounds
        run_session(64'd2, 1, 0, 0, 1'b0);     // misaligned base
        run_session(64'd0, 0, 0, 0, 1'b0);     // empty session
        run_session(64'd0, 2, 0, 0, 1'b1);     // start while busy is ignored
        run_session(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1'b0);  // top of address space
        reset_mid();
        run_session(64'd0, 4, 0, 0, 1'b0);     // clean re-load after abort

        for (int r = 0; r < 25; r++) begin
            logic [63:0] base;
            for (int i = 0; i < 8; i++) words[i] = $urandom;
            if ($urandom_range(0, 7) == 0) base = 64'($urandom_range(0, 3)) * 64'd4 + 64'($urandom_range(1, 3));
            else base = 64'($urandom_range(0, 5)) * 64'd4;
            run_session(base, int'($urandom_range(0, 6)), 0, int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
        end

        chk("writes_drained", 64'(wr_q.size()), 64'd0);
        chk("dones_drained", 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
